// File: rtl/fft_peak_search.sv
// fft_peak_search: streaming |X[k]|^2 peak finder over a programmable bin window.
// Three-stage pipeline (capture, square, sum) feeding a max tracker that reports one
// index/magnitude pair per good frame, or a framing-error pulse for a malformed frame.
module fft_peak_search #(
    parameter int FFT_POINT = 1024,
    parameter int DATA_W    = 27,
    parameter int MIN_BIN   = 1,
    parameter int MAX_BIN   = 511
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_enable,
    input  logic                         i_fft_valid,
    input  logic [63:0]                  i_fft_data,
    input  logic                         i_fft_last,
    output logic                         o_peak_valid,
    output logic [$clog2(FFT_POINT)-1:0] o_peak_idx,
    output logic [2*DATA_W:0]            o_peak_mag,
    output logic                         o_frame_err,
    output logic                         o_busy
);

    localparam int IDX_W = $clog2(FFT_POINT);
    localparam int PW    = 2 * DATA_W;
    localparam int MW    = 2 * DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_POINT - 1);
    localparam logic [IDX_W-1:0] LO_BIN   = IDX_W'(MIN_BIN);
    localparam logic [IDX_W-1:0] HI_BIN   = IDX_W'(MAX_BIN);

    // Both squares are non-negative, so zero-extending and adding is exact in MW bits.
    function automatic logic [MW-1:0] mag_sum(input logic signed [PW-1:0] a,
                                              input logic signed [PW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Upper halves of each 32-bit lane are only sign extension.
    logic unused_sign_bits;
    assign unused_sign_bits = ^{i_fft_data[63:32+DATA_W], i_fft_data[31:DATA_W]};

    logic [IDX_W-1:0] bin_cnt;
    logic             at_top, beat_end, beat_err;

    logic                     vld_p1, vld_p2, vld_p3;
    logic signed [DATA_W-1:0] re_p1, im_p1;
    logic [IDX_W-1:0]         idx_p1, idx_p2, idx_p3;
    logic                     end_p1, end_p2, end_p3;
    logic                     err_p1, err_p2, err_p3;
    logic signed [PW-1:0]     sq_re_p2, sq_im_p2;
    logic [MW-1:0]            mag_p3;

    logic             have_max;
    logic [IDX_W-1:0] max_idx;
    logic [MW-1:0]    max_mag;
    logic             in_win_p3, take_p3, issue_p3;
    logic [IDX_W-1:0] cand_idx;
    logic [MW-1:0]    cand_mag;

    // A beat closes the frame on last or on the final bin; a mismatch of the two is an error.
    assign at_top   = (bin_cnt == LAST_BIN);
    assign beat_end = i_fft_last | at_top;
    assign beat_err = i_fft_last ^ at_top;

    // Bin counter and pipeline valids; disabling flushes everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_enable) begin
            bin_cnt <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
        end else begin
            vld_p1 <= i_fft_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            if (i_fft_valid)
                bin_cnt <= beat_end ? '0 : bin_cnt + 1'b1;
        end
    end

    // Datapath registers; qualified by the valid chain, so no reset needed.
    always_ff @(posedge clk) begin
        // stage 1: capture re/im, bin index and framing flags
        re_p1  <= i_fft_data[DATA_W-1:0];
        im_p1  <= i_fft_data[32+DATA_W-1:32];
        idx_p1 <= bin_cnt;
        end_p1 <= beat_end;
        err_p1 <= beat_err;
        // stage 2: signed squares
        sq_re_p2 <= PW'(re_p1) * PW'(re_p1);
        sq_im_p2 <= PW'(im_p1) * PW'(im_p1);
        idx_p2   <= idx_p1;
        end_p2   <= end_p1;
        err_p2   <= err_p1;
        // stage 3: full-precision magnitude
        mag_p3 <= mag_sum(sq_re_p2, sq_im_p2);
        idx_p3 <= idx_p2;
        end_p3 <= end_p2;
        err_p3 <= err_p2;
    end

    // Candidate peak including the current S3 beat, so the closing beat is not missed.
    assign in_win_p3 = (idx_p3 >= LO_BIN) && (idx_p3 <= HI_BIN);
    assign take_p3   = vld_p3 && in_win_p3 && (!have_max || (mag_p3 > max_mag));
    assign issue_p3  = vld_p3 && end_p3;
    assign cand_idx  = take_p3 ? idx_p3 : max_idx;
    assign cand_mag  = take_p3 ? mag_p3 : max_mag;

    // Max tracking and once-per-frame reporting; max clears on issue for gapless frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_max     <= 1'b0;
            max_idx      <= '0;
            max_mag      <= '0;
            o_peak_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_peak_idx   <= '0;
            o_peak_mag   <= '0;
        end else if (!i_enable) begin
            have_max     <= 1'b0;
            o_peak_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_peak_valid <= issue_p3 && !err_p3;
            o_frame_err  <= issue_p3 && err_p3;
            if (issue_p3) begin
                have_max <= 1'b0;
                if (!err_p3) begin
                    o_peak_idx <= cand_idx;
                    o_peak_mag <= cand_mag;
                end
            end else if (take_p3) begin
                have_max <= 1'b1;
                max_idx  <= idx_p3;
                max_mag  <= mag_p3;
            end
        end
    end

    // Busy while a partial frame is counting or a closed frame is still in the pipeline.
    assign o_busy = (bin_cnt != '0) | (vld_p1 & end_p1) | (vld_p2 & end_p2) | (vld_p3 & end_p3);

endmodule

// File: tb/tb_fft_peak_search.sv
// tb_fft_peak_search: directed and randomized frames against a frame-level reference model.
module tb_fft_peak_search;

    localparam int N  = 1024;
    localparam int DW = 27;
    localparam int LO = 1;
    localparam int HI = 511;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_fft_valid = 1'b0;
    logic [63:0] i_fft_data = '0;
    logic        i_fft_last = 1'b0;
    logic        o_peak_valid;
    logic [9:0]  o_peak_idx;
    logic [54:0] o_peak_mag;
    logic        o_frame_err;
    logic        o_busy;

    fft_peak_search #(.FFT_POINT(N), .DATA_W(DW), .MIN_BIN(LO), .MAX_BIN(HI)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_fft_valid  (i_fft_valid),
        .i_fft_data   (i_fft_data),
        .i_fft_last   (i_fft_last),
        .o_peak_valid (o_peak_valid),
        .o_peak_idx   (o_peak_idx),
        .o_peak_mag   (o_peak_mag),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     err;
        int     idx;
        longint mag;
        int     due;
    } ev_t;

    ev_t    exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 1;          // number of the clock edge whose outputs are visible now
    int     mcnt = 0;         // reference bin counter
    longint fmag[N];
    int     held_idx = 0;
    longint held_mag = 0;
    int     fr_re[N];
    int     fr_im[N];

    task automatic chk(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        ev_t ev;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            ev = exp_q.pop_front();
            chk("peak_valid", o_peak_valid, ev.err ? 0 : 1);
            chk("frame_err", o_frame_err, ev.err ? 1 : 0);
            if (!ev.err) begin
                held_idx = ev.idx;
                held_mag = ev.mag;
            end
        end else begin
            chk("no_peak_pulse", o_peak_valid, 0);
            chk("no_err_pulse", o_frame_err, 0);
        end
        chk("peak_idx", o_peak_idx, held_idx);
        chk("peak_mag", o_peak_mag, held_mag);
        chk("busy", o_busy, (mcnt != 0 || exp_q.size() != 0) ? 1 : 0);
    endtask

    // One clock: check what the last edge produced, then drive and model the next edge.
    task automatic step(input bit rstn, input bit en, input bit v, input bit last,
                        input int re, input int im);
        ev_t ev;
        @(negedge clk);
        check_outputs();
        rst_n       = rstn;
        i_enable    = en;
        i_fft_valid = v;
        i_fft_last  = last;
        i_fft_data  = {im, re};
        cyc++;
        if (!rstn || !en) begin
            while (exp_q.size() != 0 && exp_q[exp_q.size()-1].due >= cyc)
                exp_q.delete(exp_q.size()-1);
            mcnt = 0;
            if (!rstn) begin
                held_idx = 0;
                held_mag = 0;
            end
        end else if (v) begin
            fmag[mcnt] = longint'(re) * re + longint'(im) * im;
            if (last || mcnt == N-1) begin
                ev.err = !(last && mcnt == N-1);
                ev.due = cyc + 3;
                ev.idx = LO;
                ev.mag = fmag[LO];
                for (int b = LO+1; b <= HI; b++)
                    if (fmag[b] > ev.mag) begin
                        ev.idx = b;
                        ev.mag = fmag[b];
                    end
                exp_q.push_back(ev);
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
    endtask

    task automatic clear_frame();
        for (int b = 0; b < N; b++) begin
            fr_re[b] = 0;
            fr_im[b] = 0;
        end
    endtask

    task automatic rand_frame(input int s);
        for (int b = 0; b < N; b++) begin
            fr_re[b] = int'($urandom_range(2*s-1)) - s;
            fr_im[b] = int'($urandom_range(2*s-1)) - s;
        end
    endtask

    task automatic send_frame(input int len, input bit with_last, input int gap_pct);
        for (int b = 0; b < len; b++) begin
            while (int'($urandom_range(99)) < gap_pct)
                step(1, 1, 0, 0, int'($urandom), int'($urandom));
            step(1, 1, 1, with_last && (b == len-1), fr_re[b], fr_im[b]);
        end
    endtask

    initial begin
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        idle(2);

        // tone
        clear_frame();
        fr_re[37] = 1000;
        send_frame(N, 1, 0);
        idle(5);

        // tie keeps lowest index
        clear_frame();
        fr_re[10] = 300; fr_im[10] = -400;
        fr_re[20] = 300; fr_im[20] = -400;
        send_frame(N, 1, 0);
        idle(5);

        // out-of-window bins ignored
        clear_frame();
        fr_re[0] = 5000; fr_re[600] = 9000; fr_re[100] = 20;
        send_frame(N, 1, 0);
        idle(5);

        // most negative inputs
        clear_frame();
        fr_re[5] = -(1 << 26); fr_im[5] = -(1 << 26);
        send_frame(N, 1, 0);
        idle(5);

        // all-zero frame
        clear_frame();
        send_frame(N, 1, 0);
        idle(5);

        // early last, then a clean tone, then missing last
        clear_frame();
        fr_re[3] = 77;
        send_frame(501, 1, 0);
        send_frame(N, 1, 0);
        idle(4);
        send_frame(N, 0, 0);
        idle(5);

        // back-to-back frames with gaps, ties likely at small scale
        rand_frame(4);           send_frame(N, 1, 20);
        rand_frame(1 << 26);     send_frame(N, 1, 0);
        rand_frame(1000);        send_frame(N, 1, 10);
        idle(3);

        // reset mid-frame, then clean frame
        rand_frame(500);
        send_frame(300, 0, 10);
        repeat (3) step(0, 1, 1, 0, 7, 7);
        rand_frame(2000);
        send_frame(N, 1, 5);
        idle(4);

        // enable drop mid-frame and right after a last
        send_frame(400, 0, 0);
        repeat (3) step(1, 0, 1, 1, 99, 99);
        rand_frame(3);
        send_frame(N, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(5);
        rand_frame(1 << 20);
        send_frame(N, 1, 15);
        idle(10);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
